// File: rtl/i2s_pkg.sv
`timescale 1ns/1ps
// i2s_pkg: shared I2S types and default slot geometry for the record and
// playback paths.
package i2s_pkg;

   localparam int I2S_SAMPLE_W = 24;
   localparam int I2S_SLOT_W   = 32;

   typedef enum logic [1:0] {
      HUNT,
      LEFT,
      RIGHT
   } i2s_rx_state_t;

   // Saturating 16-bit increment for event counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
`timescale 1ns/1ps
// i2s_sync_edge: multi-flop synchroniser for one asynchronous audio pin,
// plus a registered previous value to detect a rising edge in the clk domain.
module i2s_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic din,
   output logic level,
   output logic rise
);

   logic [STAGES-1:0] chain_q;
   logic              prev_q;

   // Shift the pin through the synchroniser and remember the last synced level.
   // NOTE: the chain is reset so no spurious edge or X leaves it after reset;
   // every flop here is real state, not a memory array, so a reset is cheap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         chain_q <= '0;
         prev_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep each stage reading the
         // previous-cycle value of its neighbour.
         chain_q <= {chain_q[STAGES-2:0], din};
         prev_q  <= chain_q[STAGES-1];
      end
   end

   assign level = chain_q[STAGES-1];
   assign rise  = level & ~prev_q;

endmodule

// File: rtl/i2s_rx_capture.sv
`timescale 1ns/1ps
// i2s_rx_capture: standard-I2S record-path receiver. Oversamples the codec's
// BCLK/LRC/DAT pins in the clk domain, deserialises left/right words and
// presents each pair on a valid/ready stream.
// Optional build macro I2S_RX_STATS_EN adds saturating dropped-pair and
// short-word counters; without it both counter ports read 0.
module i2s_rx_capture
   import i2s_pkg::*;
#(
   parameter int SAMPLE_W    = I2S_SAMPLE_W,
   parameter int SLOT_W      = I2S_SLOT_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                audio_I2S_recbclk,
   input  logic                audio_I2S_reclrc,
   input  logic                audio_I2S_recdat,
   output logic [SAMPLE_W-1:0] m_tdata_l,
   output logic [SAMPLE_W-1:0] m_tdata_r,
   output logic                m_tvalid,
   input  logic                m_tready,
   output logic                locked,
   output logic                overflow,
   output logic                frame_err,
   output logic [15:0]         ovf_count,
   output logic [15:0]         err_count
);

   // Bit counter is sized for a whole slot even though it holds at SAMPLE_W.
   localparam int               CNT_W    = $clog2(SLOT_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SAMPLE_W);

   logic bit_tick;
   logic lrc_s;
   logic dat_s;
   logic lrc_rise_unused;
   logic dat_rise_unused;

   i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
      .clk   (clk),
      .rstn  (rstn),
      .din   (audio_I2S_recbclk),
      .level (),
      .rise  (bit_tick)
   );

   i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrc (
      .clk   (clk),
      .rstn  (rstn),
      .din   (audio_I2S_reclrc),
      .level (lrc_s),
      .rise  (lrc_rise_unused)
   );

   i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dat (
      .clk   (clk),
      .rstn  (rstn),
      .din   (audio_I2S_recdat),
      .level (dat_s),
      .rise  (dat_rise_unused)
   );

   logic                lrc_prev_q;
   logic [CNT_W-1:0]    bitcnt_q;
   logic [SAMPLE_W-2:0] shift_q;
   logic [SAMPLE_W-1:0] left_hold_q;
   logic [SAMPLE_W-1:0] new_word;
   logic                boundary;
   logic                word_done;
   logic                slot_full;

   i2s_rx_state_t state_q, state_d;
   logic          short_word;
   logic          left_done;
   logic          pair_done;

   // The bit sampled on a boundary tick is the previous slot's LSB and is dropped.
   assign boundary  = bit_tick && (lrc_s != lrc_prev_q);
   assign word_done = bit_tick && !boundary && (bitcnt_q == LAST_BIT);
   assign slot_full = (bitcnt_q == FULL_CNT);
   assign new_word  = {shift_q, dat_s};

   // Serial capture: restart the bit count on every LRC change, shift MSB-first
   // until SAMPLE_W bits are in, then ignore the rest of the slot.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lrc_prev_q <= 1'b0;
         bitcnt_q   <= '0;
         shift_q    <= '0;
      end else if (bit_tick) begin
         if (boundary) begin
            lrc_prev_q <= lrc_s;
            bitcnt_q   <= '0;
         end else if (bitcnt_q < FULL_CNT) begin
            shift_q  <= new_word[SAMPLE_W-2:0];
            bitcnt_q <= bitcnt_q + CNT_W'(1);
         end
      end
   end

   // State register for the frame-alignment FSM.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Frame alignment: find a left slot, complete left then right, and treat any
   // boundary before a full word as a short word that abandons the pair.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d    = state_q;
      short_word = 1'b0;
      left_done  = 1'b0;
      pair_done  = 1'b0;
      unique case (state_q)
         HUNT: begin
            if (boundary && !lrc_s) state_d = LEFT;
         end
         LEFT: begin
            if (boundary) begin
               if (!slot_full) begin
                  short_word = 1'b1;
                  state_d    = lrc_s ? HUNT : LEFT;
               end else if (lrc_s) begin
                  state_d = RIGHT;
               end
            end else if (word_done) begin
               left_done = 1'b1;
            end
         end
         RIGHT: begin
            if (boundary) begin
               if (!slot_full) begin
                  short_word = 1'b1;
                  state_d    = lrc_s ? HUNT : LEFT;
               end else if (!lrc_s) begin
                  state_d = LEFT;
               end
            end else if (word_done) begin
               pair_done = 1'b1;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // Hold the completed left word until its right partner arrives.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         left_hold_q <= '0;
      end else if (left_done) begin
         left_hold_q <= new_word;
      end
   end

   // Output stream: load a finished pair unless the consumer is stalling an
   // older one, in which case drop the new pair and flag overflow.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_tvalid  <= 1'b0;
         m_tdata_l <= '0;
         m_tdata_r <= '0;
         overflow  <= 1'b0;
      end else if (pair_done) begin
         if (m_tvalid && !m_tready) begin
            overflow <= 1'b1;
         end else begin
            m_tvalid  <= 1'b1;
            m_tdata_l <= left_hold_q;
            m_tdata_r <= new_word;
         end
      end else if (m_tvalid && m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

   // Lock status and the single-cycle short-word pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         locked    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= short_word;
         if (state_d == HUNT) begin
            locked <= 1'b0;
         end else if (pair_done) begin
            locked <= 1'b1;
         end
      end
   end

`ifdef I2S_RX_STATS_EN
   logic [15:0] ovf_cnt_q;
   logic [15:0] err_cnt_q;
   logic        pair_drop;

   assign pair_drop = pair_done && m_tvalid && !m_tready;

   // Saturating counts of dropped pairs and short-word pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         if (pair_drop) ovf_cnt_q <= sat_inc16(ovf_cnt_q);
         if (frame_err) err_cnt_q <= sat_inc16(err_cnt_q);
      end
   end

   assign ovf_count = ovf_cnt_q;
   assign err_count = err_cnt_q;
`else
   assign ovf_count = '0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_i2s_rx_capture.sv
`timescale 1ns/1ps
// tb_i2s_rx_capture: directed bench driving I2S frames from a modelled codec
// (BCLK ~3.07 MHz, 64 fs) into i2s_rx_capture running on a 100 MHz clk.
module tb_i2s_rx_capture;

   localparam real HALF = 162.5;
`ifdef I2S_RX_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic        clk;
   logic        rstn;
   logic        audio_I2S_recbclk;
   logic        audio_I2S_reclrc;
   logic        audio_I2S_recdat;
   logic [23:0] m_tdata_l;
   logic [23:0] m_tdata_r;
   logic        m_tvalid;
   logic        m_tready;
   logic        locked;
   logic        overflow;
   logic        frame_err;
   logic [15:0] ovf_count;
   logic [15:0] err_count;

   int n_cmp = 0;
   int n_bad = 0;
   int err_cycles = 0;
   logic [23:0] q_l[$];
   logic [23:0] q_r[$];

   i2s_rx_capture dut (
      .clk               (clk),
      .rstn              (rstn),
      .audio_I2S_recbclk (audio_I2S_recbclk),
      .audio_I2S_reclrc  (audio_I2S_reclrc),
      .audio_I2S_recdat  (audio_I2S_recdat),
      .m_tdata_l         (m_tdata_l),
      .m_tdata_r         (m_tdata_r),
      .m_tvalid          (m_tvalid),
      .m_tready          (m_tready),
      .locked            (locked),
      .overflow          (overflow),
      .frame_err         (frame_err),
      .ovf_count         (ovf_count),
      .err_count         (err_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record every transfer (valid && ready ahead of the next edge) and count
   // cycles with frame_err high.
   always @(negedge clk) begin
      if (rstn && m_tvalid && m_tready) begin
         q_l.push_back(m_tdata_l);
         q_r.push_back(m_tdata_r);
      end
      if (frame_err) err_cycles++;
   end

   // One BCLK period: codec changes LRC/DAT on the falling edge.
   task automatic bclk_bit(input logic lrc_v, input logic dat_v);
      audio_I2S_recbclk = 1'b0;
      audio_I2S_reclrc  = lrc_v;
      audio_I2S_recdat  = dat_v;
      #(HALF);
      audio_I2S_recbclk = 1'b1;
      #(HALF);
   endtask

   // One slot: boundary bit, nbits of word MSB first, zero padding to 32 if full.
   task automatic send_slot(input logic lrc_v, input logic [23:0] word, input int nbits);
      bclk_bit(lrc_v, 1'b0);
      for (int i = 0; i < nbits; i++) bclk_bit(lrc_v, word[23-i]);
      if (nbits >= 24) for (int i = nbits + 1; i < 32; i++) bclk_bit(lrc_v, 1'b0);
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
      send_slot(1'b0, l, 24);
      send_slot(1'b1, r, 24);
   endtask

   task automatic pop_pair(output logic [23:0] l, output logic [23:0] r);
      if (q_l.size() > 0) begin
         l = q_l.pop_front();
         r = q_r.pop_front();
      end else begin
         l = 'x;
         r = 'x;
      end
   endtask

   task automatic test_reset();
      logic [23:0] l, r;
      rstn = 1'b0; m_tready = 1'b1;
      audio_I2S_recbclk = 1'b0; audio_I2S_reclrc = 1'b0; audio_I2S_recdat = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %0h expected 0", m_tvalid); end
      n_cmp++; if (m_tdata_l !== 24'h0) begin n_bad++; $display("FAIL rst_tdata_l: got %0h expected 0", m_tdata_l); end
      n_cmp++; if (m_tdata_r !== 24'h0) begin n_bad++; $display("FAIL rst_tdata_r: got %0h expected 0", m_tdata_r); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %0h expected 0", locked); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %0h expected 0", overflow); end
      n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_frame_err: got %0h expected 0", frame_err); end
      n_cmp++; if (ovf_count !== 16'h0) begin n_bad++; $display("FAIL rst_ovf_count: got %0h expected 0", ovf_count); end
      n_cmp++; if (err_count !== 16'h0) begin n_bad++; $display("FAIL rst_err_count: got %0h expected 0", err_count); end
      rstn = 1'b1;
      @(posedge clk); #3;
      // No LRC falling edge precedes this frame, so nothing may be emitted.
      send_frame(24'h111111, 24'h222222);
      n_cmp++; if (q_l.size() !== 0) begin n_bad++; $display("FAIL rst_no_emit: got %0d pairs expected 0", q_l.size()); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked_hunt: got %0h expected 0", locked); end
      while (q_l.size() > 0) pop_pair(l, r);
   endtask

   task automatic test_basic();
      logic [23:0] l, r;
      logic [23:0] exp_l[3] = '{24'h123456, 24'h7FFFFF, 24'h000000};
      logic [23:0] exp_r[3] = '{24'hABCDEF, 24'h800000, 24'hFFFFFF};
      for (int f = 0; f < 3; f++) begin
         send_frame(exp_l[f], exp_r[f]);
         n_cmp++; if (q_l.size() !== 1) begin n_bad++; $display("FAIL basic_count%0d: got %0d pairs expected 1", f, q_l.size()); end
         pop_pair(l, r);
         n_cmp++; if (l !== exp_l[f]) begin n_bad++; $display("FAIL basic_l%0d: got %h expected %h", f, l, exp_l[f]); end
         n_cmp++; if (r !== exp_r[f]) begin n_bad++; $display("FAIL basic_r%0d: got %h expected %h", f, r, exp_r[f]); end
         n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL basic_tvalid%0d: got %0h expected 0", f, m_tvalid); end
         n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL basic_locked%0d: got %0h expected 1", f, locked); end
      end
   endtask

   task automatic test_simultaneous();
      logic [23:0] l, r;
      logic [23:0] s2_r = 24'h0D0D0D;
      realtime t0;
      @(posedge clk); #1 m_tready = 1'b0;
      send_frame(24'h0A0A0A, 24'h0B0B0B);
      send_slot(1'b0, 24'h0C0C0C, 24);
      bclk_bit(1'b1, 1'b0);
      for (int i = 0; i < 23; i++) bclk_bit(1'b1, s2_r[23-i]);
      // Last right bit: raise ready exactly for the clk edge that emits.
      audio_I2S_recbclk = 1'b0;
      audio_I2S_recdat  = s2_r[0];
      #(HALF);
      audio_I2S_recbclk = 1'b1;
      t0 = $realtime;
      @(posedge clk); @(posedge clk); #1 m_tready = 1'b1;
      @(posedge clk); #1 m_tready = 1'b0;
      #(HALF - ($realtime - t0));
      for (int i = 25; i < 32; i++) bclk_bit(1'b1, 1'b0);
      n_cmp++; if (q_l.size() !== 1) begin n_bad++; $display("FAIL sim_count: got %0d pairs expected 1", q_l.size()); end
      pop_pair(l, r);
      n_cmp++; if ({l, r} !== {24'h0A0A0A, 24'h0B0B0B}) begin n_bad++; $display("FAIL sim_old_pair: got %h/%h expected 0a0a0a/0b0b0b", l, r); end
      n_cmp++; if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL sim_tvalid: got %0h expected 1", m_tvalid); end
      n_cmp++; if ({m_tdata_l, m_tdata_r} !== {24'h0C0C0C, 24'h0D0D0D}) begin n_bad++; $display("FAIL sim_new_pair: got %h/%h expected 0c0c0c/0d0d0d", m_tdata_l, m_tdata_r); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL sim_overflow: got %0h expected 0", overflow); end
      @(posedge clk); #1 m_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      pop_pair(l, r);
      n_cmp++; if ({l, r} !== {24'h0C0C0C, 24'h0D0D0D}) begin n_bad++; $display("FAIL sim_drain: got %h/%h expected 0c0c0c/0d0d0d", l, r); end
   endtask

   task automatic test_backpressure();
      logic [23:0] l, r;
      logic [15:0] exp_ovf = (STATS != 0) ? 16'd2 : 16'd0;
      @(posedge clk); #1 m_tready = 1'b0;
      send_frame(24'h000001, 24'h000002);
      n_cmp++; if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL bp_tvalid: got %0h expected 1", m_tvalid); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_ovf_early: got %0h expected 0", overflow); end
      send_frame(24'h000003, 24'h000004);
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_overflow: got %0h expected 1", overflow); end
      send_frame(24'h000005, 24'h000006);
      n_cmp++; if ({m_tdata_l, m_tdata_r} !== {24'h000001, 24'h000002}) begin n_bad++; $display("FAIL bp_held: got %h/%h expected 000001/000002", m_tdata_l, m_tdata_r); end
      n_cmp++; if (ovf_count !== exp_ovf) begin n_bad++; $display("FAIL bp_ovf_count: got %0d expected %0d", ovf_count, exp_ovf); end
      @(posedge clk); #1 m_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (q_l.size() !== 1) begin n_bad++; $display("FAIL bp_count: got %0d pairs expected 1", q_l.size()); end
      pop_pair(l, r);
      n_cmp++; if ({l, r} !== {24'h000001, 24'h000002}) begin n_bad++; $display("FAIL bp_transfer: got %h/%h expected 000001/000002", l, r); end
      n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL bp_tvalid_after: got %0h expected 0", m_tvalid); end
   endtask

   task automatic test_mid_frame();
      logic [23:0] l, r;
      send_slot(1'b0, 24'hAAAAAA, 24);
      send_slot(1'b1, 24'h555555, 11);
      rstn = 1'b0;
      #50;
      n_cmp++; if ({m_tvalid, locked, overflow, frame_err} !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_flags: got %b expected 0000", {m_tvalid, locked, overflow, frame_err}); end
      n_cmp++; if ({m_tdata_l, m_tdata_r} !== 48'h0) begin n_bad++; $display("FAIL mid_rst_data: got %h/%h expected 0/0", m_tdata_l, m_tdata_r); end
      n_cmp++; if ({ovf_count, err_count} !== 32'h0) begin n_bad++; $display("FAIL mid_rst_counts: got %h/%h expected 0/0", ovf_count, err_count); end
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #3;
      // Resume inside the right slot: this partial frame must be discarded.
      for (int i = 0; i < 20; i++) bclk_bit(1'b1, 1'b1);
      n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_no_emit: got %0h expected 0", m_tvalid); end
      send_frame(24'h13579B, 24'h2468AC);
      n_cmp++; if (q_l.size() !== 1) begin n_bad++; $display("FAIL mid_count: got %0d pairs expected 1", q_l.size()); end
      pop_pair(l, r);
      n_cmp++; if ({l, r} !== {24'h13579B, 24'h2468AC}) begin n_bad++; $display("FAIL mid_first_pair: got %h/%h expected 13579b/2468ac", l, r); end
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL mid_locked: got %0h expected 1", locked); end
   endtask

   task automatic test_short_word();
      logic [23:0] l, r;
      int e0 = err_cycles;
      // Short left word: LRC toggles after 10 left bits.
      send_slot(1'b0, 24'hFFFFFF, 10);
      send_slot(1'b1, 24'h00FF00, 24);
      n_cmp++; if (err_cycles - e0 !== 1) begin n_bad++; $display("FAIL sw_pulse: got %0d cycles expected 1", err_cycles - e0); end
      n_cmp++; if (err_count !== 16'(STATS)) begin n_bad++; $display("FAIL sw_err_count: got %0d expected %0d", err_count, STATS); end
      n_cmp++; if (q_l.size() !== 0) begin n_bad++; $display("FAIL sw_no_emit: got %0d pairs expected 0", q_l.size()); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL sw_unlocked: got %0h expected 0", locked); end
      send_frame(24'h800001, 24'h7FFFFE);
      pop_pair(l, r);
      n_cmp++; if ({l, r} !== {24'h800001, 24'h7FFFFE}) begin n_bad++; $display("FAIL sw_recover: got %h/%h expected 800001/7ffffe", l, r); end
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL sw_relock: got %0h expected 1", locked); end
      // Short right word: pair abandoned, capture continues in the next left slot.
      send_slot(1'b0, 24'h111111, 24);
      send_slot(1'b1, 24'h222222, 10);
      send_frame(24'h333333, 24'h444444);
      n_cmp++; if (err_cycles - e0 !== 2) begin n_bad++; $display("FAIL sw_pulse2: got %0d cycles expected 2", err_cycles - e0); end
      n_cmp++; if (err_count !== 16'(2 * STATS)) begin n_bad++; $display("FAIL sw_err_count2: got %0d expected %0d", err_count, 2 * STATS); end
      n_cmp++; if (q_l.size() !== 1) begin n_bad++; $display("FAIL sw_count2: got %0d pairs expected 1", q_l.size()); end
      pop_pair(l, r);
      n_cmp++; if ({l, r} !== {24'h333333, 24'h444444}) begin n_bad++; $display("FAIL sw_next_pair: got %h/%h expected 333333/444444", l, r); end
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL sw_locked2: got %0h expected 1", locked); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_simultaneous();
      test_backpressure();
      test_mid_frame();
      test_short_word();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2s_rx_capture.md
Name: i2s_rx_capture

Overview:
Record-path I2S receiver for the on-board audio codec ADC: samples the codec's record bit clock, record LR clock and record data pins in the fabric `clk` domain. Deserialises standard I2S frames (MSB one BCLK after the LRCLK edge, left channel while LRCLK low) into left/right sample pairs. Presents each pair on a valid/ready stream toward the synth/PS side. Codec is master; this block never drives the audio pins.

Parameters:
SAMPLE_W, 24, captured bits per channel (MSB first)
SLOT_W, 32, BCLK periods per half-frame; bits after SAMPLE_W are ignored
SYNC_STAGES, 2, flop stages on each async audio input (min 2)

Ports:
clk  in  1  fabric clock (FCLK, 100 MHz), must be >= 8x BCLK
rstn  in  1  asynchronous active-low reset
audio_I2S_recbclk  in  1  codec record bit clock (async)
audio_I2S_reclrc  in  1  codec record LR clock (async)
audio_I2S_recdat  in  1  codec record serial data (async)
m_tdata_l  out  SAMPLE_W  left sample, two's complement, unmodified
m_tdata_r  out  SAMPLE_W  right sample
m_tvalid  out  1  pair available
m_tready  in  1  consumer accepts pair
locked  out  1  high once a complete frame has been captured; low in HUNT
overflow  out  1  sticky: a pair was dropped; cleared only by reset
frame_err  out  1  one-clk pulse on short word
ovf_count  out  16  dropped-pair count (see Optional Feature)
err_count  out  16  short-word count (see Optional Feature)

Behaviour:
- Reset (rstn low, async): all outputs 0, state HUNT, shift/bit counters 0, sync chains 0.
- All three pins pass through SYNC_STAGES flops; equal depth keeps them mutually aligned. `bit_tick` = synced BCLK rising edge (synced 1, previous 0), one clk wide. All capture logic advances only on bit_tick.
- Boundary: on bit_tick with synced LRC != lrc_prev, lrc_prev updates, bitcnt <= 0. The bit sampled on that tick belongs to the previous slot and is discarded.
- On a non-boundary bit_tick with bitcnt < SAMPLE_W: shift the data bit in at the LSB and increment bitcnt. When bitcnt == SAMPLE_W, hold. Bits SAMPLE_W+1..SLOT_W are ignored.
- FSM:
  - HUNT: wait for a boundary with new LRC=0, then go to LEFT.
  - LEFT: when bitcnt reaches SAMPLE_W, latch left_hold. On boundary to LRC=1, go to RIGHT.
  - RIGHT: when bitcnt reaches SAMPLE_W, emit the pair. On boundary to LRC=0, go to LEFT.
- Short word: a boundary arriving with bitcnt < SAMPLE_W in LEFT or RIGHT pulses frame_err, discards the partial pair, and re-enters LEFT (new LRC=0) or HUNT (new LRC=1). locked drops only in HUNT.
- Emit: m_tvalid and m_tdata_* update on the clk after the bit_tick that shifts in the SAMPLE_W-th right bit.
- Handshake: the pair transfers on the clk where m_tvalid && m_tready. Data is stable while m_tvalid=1 && m_tready=0. m_tvalid deasserts after a transfer unless a new pair loads in the same cycle.
- Emit while m_tvalid=1 and m_tready=0: the new pair is dropped, the old pair is kept, overflow is set.
- Emit while m_tvalid=1 and m_tready=1 in the same clk: the old pair transfers, the new pair loads, m_tvalid stays 1, no overflow.
- locked goes high on the first emit after HUNT.
- BCLK stopping mid-frame: state is held indefinitely with no timeout. Recovery is through the short-word path or reset.

Optional Feature:
- Macro: I2S_RX_STATS_EN.
- Defined: ovf_count increments on every dropped pair; err_count increments on every frame_err pulse. Both saturate at 16'hFFFF and reset to 0.
- Undefined: counters are not built and both ports are tied to 0. The port list is identical either way.

Decomposition:
- Package i2s_pkg holds:
  - typedef enum i2s_rx_state_t {HUNT, LEFT, RIGHT};
  - localparam defaults I2S_SAMPLE_W=24 and I2S_SLOT_W=32, shared with the playback generator.
- Sub-module i2s_sync_edge: SYNC_STAGES synchroniser plus a registered previous value. Outputs the synced level and a rise pulse. Instantiated once each for BCLK, LRC and DAT; rise is unused for LRC and DAT.

Test Plan:
- Reset behaviour: assert rstn=0 mid-frame, release -> all outputs 0, state HUNT, locked=0, and no m_tvalid until a full left+right frame follows an LRC falling edge.
- Basic capture: BCLK 3.072 MHz (64 fs), clk 100 MHz, frames L=0x123456 R=0xABCDEF, m_tready=1 -> m_tdata_l=0x123456, m_tdata_r=0xABCDEF, one m_tvalid pulse per frame, locked=1.
- Mid-frame start: begin stimulus inside a right slot -> that partial frame is discarded, and the first emitted pair is the next full frame.
- Backpressure: hold m_tready=0 for 3 frames (0x000001/0x000002, 0x000003/0x000004, ...) -> first pair held stable, overflow=1, ovf_count=2 with I2S_RX_STATS_EN. m_tready=1 -> 0x000001/0x000002 transfers.
- Simultaneous event: assert m_tready on the exact clk a new pair emits -> old pair transfers, new pair loads, m_tvalid stays 1, overflow stays 0.
- Short word: toggle LRC after 10 left bits -> frame_err single-clk pulse, err_count=1, no pair emitted for that frame, the next full frame is captured correctly.
